mult_arbiter: RTL and testbench
===============================

Name: mult_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational 4x4 unsigned multiplier between NUM_REQ requesters.
- Typical requesters are the vending FSM's price-times-quantity path and the change/refund computation.
- The block grants one requester at a time, drives registered operands to the shared multiplier, captures the 8-bit product, and returns it with a one-cycle done pulse.
- It sits between the requesting control blocks and a single multiplier instance; the multiplier itself stays outside this block.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-requester request level; bit i belongs to requester i.
- op_a  input  4*NUM_REQ  multiplicands; requester i uses bits [4i+3:4i].
- op_b  input  4*NUM_REQ  multipliers; same slicing as op_a.
- grant  output  NUM_REQ  one-hot grant, registered.
- mul_a  output  4  registered operand A to the shared multiplier.
- mul_b  output  4  registered operand B to the shared multiplier.
- mul_p  input  8  product returned by the shared multiplier (combinational from mul_a/mul_b).
- result  output  8  registered product of the last completed operation.
- done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, grant=0, mul_a=0, mul_b=0, result=0, done=0, busy=0, round-robin pointer=0.
- Reset mid-operation aborts immediately: no done pulse is produced and the pointer returns to 0.
- State IDLE:
  - If any req bit is high at the edge, select the first requesting index at or after the pointer, scanning upward and wrapping modulo NUM_REQ.
  - On that edge: grant<=onehot(sel), mul_a<=op_a slice of sel, mul_b<=op_b slice of sel, next state CALC.
  - If no req bit is high, stay in IDLE; all outputs hold.
- State CALC: one settle cycle for the multiplier. On the edge: result<=mul_p, next state DONE.
- State DONE:
  - done = grant, decoded combinationally from state and grant, so it is high for exactly one cycle.
  - On the edge: pointer<=sel+1 modulo NUM_REQ, grant<=0, next state IDLE.
- Latency: req sampled at edge N; grant high after N; result valid after N+1; done high during the cycle after N+1. Total 2 cycles accept-to-done; one operation per 3 cycles.
- Request and operand sampling:
  - req and operands are sampled only in IDLE. Operand changes after acceptance have no effect.
  - Dropping req during CALC or DONE does not abort; the result is still delivered.
- Requesters hold req until they see done and drop it the cycle after. A req still high in IDLE after its own done is treated as a new request, arbitrated at lowest priority because the pointer has advanced.
- Simultaneous requests: only one is granted per operation; the others wait with req held. Maximum wait is NUM_REQ-1 operations.
- result holds its value until the next CALC->DONE capture and is valid to read while done is high.
- Arithmetic: unsigned 4x4 -> 8 bit; maximum 15*15=225; no overflow is possible.

Optional Feature:
- Macro MULT_ARB_ZERO_BYPASS_EN.
- Defined: when the selected op_a slice or op_b slice is 0 at acceptance, IDLE goes directly to DONE, with result<=0 and mul_a/mul_b loaded as normal. done appears 1 cycle after acceptance instead of 2; pointer update is unchanged.
- Undefined: zero operands take the normal CALC path with 2-cycle latency; result=0 comes from mul_p.

Test Plan:
- Reset: rst_n=0 with req=2'b11 -> grant=0, done=0, result=0, busy=0; after release, grant=2'b01 on the first edge.
- Single op: req[0]=1, op_a[3:0]=7, op_b[3:0]=9 -> grant=01, mul_a=7, mul_b=9; done[0] high 2 cycles after acceptance with result=63; busy low afterwards.
- Fairness: req=11 held continuously with operands (15,15) and (3,4) -> done sequence 01,10,01,10 with results 225,12,225,12, one operation per 3 cycles.
- Mid-op change: after acceptance of (5,6), change op_a[3:0] to 2 and drop req[0] in CALC -> result=30 and done[0] still pulses.
- Reset in CALC: assert rst_n=0 during CALC -> no done pulse; on restart with req=11, requester 0 is granted first.
- Zero bypass, macro defined: (0,13) -> done 1 cycle after acceptance with result=0. Macro undefined: same stimulus -> done after 2 cycles with result=0.

Source files
------------

// File: rtl/mult_arbiter_if.sv
// Requester/multiplier-side bundle for mult_arbiter: per-requester request and operands,
// grant/done back to requesters, and the operand/product pair to the shared multiplier.
interface mult_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [4*NUM_REQ-1:0] op_a;
    logic [4*NUM_REQ-1:0] op_b;
    logic [NUM_REQ-1:0]   grant;
    logic [3:0]           mul_a;
    logic [3:0]           mul_b;
    logic [7:0]           mul_p;
    logic [7:0]           result;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;

    modport master (
        output req, op_a, op_b, mul_p,
        input  grant, mul_a, mul_b, result, done, busy
    );

    modport slave (
        input  req, op_a, op_b, mul_p,
        output grant, mul_a, mul_b, result, done, busy
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one external 4x4 multiplier; MULT_ARB_ZERO_BYPASS_EN skips CALC on a zero operand.
// Accept-to-done 2 cycles (1 with bypass); losers wait with req held, at most NUM_REQ-1 operations.
module mult_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_arbiter_if.slave  bus
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        sel_q;
    logic [NUM_REQ-1:0]   grant;
    logic [3:0]           mul_a;
    logic [3:0]           mul_b;
    logic [7:0]           result;

    logic                 found;
    logic [PW-1:0]        sel;
    logic [PW-1:0]        cand;
    logic [3:0]           sel_a;
    logic [3:0]           sel_b;
    logic                 zero_op;
    logic [PW-1:0]        ptr_nxt;

    // First requester at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PW'((int'(ptr) + k) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == PW'(i)) begin
                sel_a = bus.op_a[4*i +: 4];
                sel_b = bus.op_b[4*i +: 4];
            end
        end
    end

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign zero_op = (sel_a == 4'd0) || (sel_b == 4'd0);
`else
    assign zero_op = 1'b0;
`endif

    assign ptr_nxt = (sel_q == PW'(NUM_REQ - 1)) ? '0 : sel_q + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = zero_op ? DONE : CALC;
            CALC:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            sel_q  <= '0;
            grant  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= NUM_REQ'(1) << sel;
                        mul_a <= sel_a;
                        mul_b <= sel_b;
                        sel_q <= sel;
                        if (zero_op) result <= '0;
                    end
                end
                CALC: result <= bus.mul_p;
                DONE: begin
                    grant <= '0;
                    ptr   <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant  = grant;
    assign bus.mul_a  = mul_a;
    assign bus.mul_b  = mul_b;
    assign bus.result = result;
    assign bus.done   = (state == DONE) ? grant : '0;
    assign bus.busy   = (state != IDLE);
endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with the shared multiplier modelled as a plain product.
module tb_mult_arbiter;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    mult_arbiter_if #(.NUM_REQ(2)) bus ();

    mult_arbiter #(.NUM_REQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mul_p = bus.mul_a * bus.mul_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [3:0] a0, input logic [3:0] b0,
                           input logic [3:0] a1, input logic [3:0] b1);
        bus.op_a = {a1, a0};
        bus.op_b = {b1, b0};
    endtask

    logic [1:0] exp_g [4];
    logic [7:0] exp_r [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp_g  = '{2'b10, 2'b01, 2'b10, 2'b01};
        exp_r  = '{8'd12, 8'd225, 8'd12, 8'd225};

        // Reset held with both requesting
        rst_n   = 1'b0;
        bus.req = 2'b11;
        set_ops(4'd7, 4'd9, 4'd3, 4'd4);
        tick();
        tick();
        chk("rst_grant",  32'(bus.grant),  32'd0);
        chk("rst_done",   32'(bus.done),   32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_busy",   32'(bus.busy),   32'd0);
        chk("rst_mul_a",  32'(bus.mul_a),  32'd0);

        // Single operation on requester 0: 7*9
        rst_n = 1'b1;
        tick();
        chk("single_grant", 32'(bus.grant), 32'b01);
        chk("single_mul_a", 32'(bus.mul_a), 32'd7);
        chk("single_mul_b", 32'(bus.mul_b), 32'd9);
        chk("single_busy",  32'(bus.busy),  32'd1);
        chk("single_done0", 32'(bus.done),  32'd0);
        bus.req = 2'b01;
        tick();
        chk("single_done",   32'(bus.done),   32'b01);
        chk("single_result", 32'(bus.result), 32'd63);
        bus.req = 2'b00;
        tick();
        chk("single_idle_busy",  32'(bus.busy),   32'd0);
        chk("single_idle_done",  32'(bus.done),   32'd0);
        chk("single_idle_grant", 32'(bus.grant),  32'd0);
        chk("single_hold_res",   32'(bus.result), 32'd63);

        // Fairness: pointer now at 1, both held
        bus.req = 2'b11;
        set_ops(4'd15, 4'd15, 4'd3, 4'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fair_grant",    32'(bus.grant), 32'(exp_g[i]));
            chk("fair_acc_done", 32'(bus.done),  32'd0);
            tick();
            chk("fair_done",   32'(bus.done),   32'(exp_g[i]));
            chk("fair_result", 32'(bus.result), 32'(exp_r[i]));
            tick();
            chk("fair_idle_busy", 32'(bus.busy), 32'd0);
        end
        bus.req = 2'b00;
        tick();
        chk("fair_end_busy", 32'(bus.busy), 32'd0);

        // Operand change and req drop after acceptance
        bus.req = 2'b01;
        set_ops(4'd5, 4'd6, 4'd3, 4'd4);
        tick();
        chk("mid_grant", 32'(bus.grant), 32'b01);
        bus.op_a[3:0] = 4'd2;
        bus.req       = 2'b00;
        tick();
        chk("mid_done",   32'(bus.done),   32'b01);
        chk("mid_result", 32'(bus.result), 32'd30);
        tick();
        chk("mid_idle_done", 32'(bus.done), 32'd0);

        // Reset during CALC: pointer is 1 so requester 1 wins first
        bus.req = 2'b11;
        set_ops(4'd7, 4'd9, 4'd3, 4'd4);
        tick();
        chk("rcalc_grant", 32'(bus.grant), 32'b10);
        rst_n = 1'b0;
        #1;
        chk("rcalc_async_grant", 32'(bus.grant), 32'd0);
        chk("rcalc_async_busy",  32'(bus.busy),  32'd0);
        tick();
        chk("rcalc_no_done", 32'(bus.done),   32'd0);
        chk("rcalc_result",  32'(bus.result), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rcalc_restart_grant", 32'(bus.grant), 32'b01);
        tick();
        chk("rcalc_restart_done",   32'(bus.done),   32'b01);
        chk("rcalc_restart_result", 32'(bus.result), 32'd63);
        bus.req = 2'b00;
        tick();

        // Zero operand on requester 0: 0*13
        bus.req = 2'b01;
        set_ops(4'd0, 4'd13, 4'd3, 4'd4);
        tick();
        chk("zero_grant", 32'(bus.grant), 32'b01);
        chk("zero_mul_b", 32'(bus.mul_b), 32'd13);
`ifdef MULT_ARB_ZERO_BYPASS_EN
        chk("zero_done",   32'(bus.done),   32'b01);
        chk("zero_result", 32'(bus.result), 32'd0);
        bus.req = 2'b00;
`else
        chk("zero_calc_done", 32'(bus.done),   32'd0);
        chk("zero_calc_res",  32'(bus.result), 32'd63);
        tick();
        chk("zero_done",   32'(bus.done),   32'b01);
        chk("zero_result", 32'(bus.result), 32'd0);
        bus.req = 2'b00;
`endif
        tick();
        chk("zero_end_busy", 32'(bus.busy), 32'd0);
        chk("zero_end_done", 32'(bus.done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
        $finish;
    end
endmodule
